stack_queue: RTL and testbench
==============================

STACK_QUEUE -- requirements
Module: stack_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of storage entries, legal range 2 or more, any integer (not restricted to powers of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per entry.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: almost_full assertion level, legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port syn_n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port mode_i, input, 1 bit: requested mode, 0 = LIFO, 1 = FIFO.
REQ-007 SHALL have port push, input, 1 bit: write request.
REQ-008 SHALL have port pop, input, 1 bit: read request.
REQ-009 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-010 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-011 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-013 SHALL have port data_valid, output, 1 bit: data_out was updated by a pop in the previous cycle.
REQ-014 SHALL have port count, output, ceil(log2(DEPTH+1)) bits: current number of stored entries.
REQ-015 SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-016 SHALL have port empty, output, 1 bit: count equals 0.
REQ-017 SHALL have port almost_full, output, 1 bit: count is at least AF_THRESH.
REQ-018 SHALL have port mode_o, output, 1 bit: currently active mode.
REQ-019 SHALL have port overflow, output, 1 bit: sticky flag for a rejected push.
REQ-020 SHALL have port underflow, output, 1 bit: sticky flag for a rejected pop.

Function
REQ-021 SHALL accept a pop (pop_acc) when pop is 1 and empty is 0.
REQ-022 SHALL accept a push (push_acc) when push is 1 and either full is 0 or pop_acc is 1.
REQ-023 SHALL, on pop_acc, load data_out at the next edge with the element selected by mode_o and set data_valid to 1 for that one cycle. LIFO mode selects the most recently written element; FIFO mode selects the oldest element. Read latency is 1 cycle.
REQ-024 SHALL hold data_out and drive data_valid to 0 in every cycle without pop_acc.
REQ-025 SHALL update count as +1 for push_acc only, -1 for pop_acc only, and unchanged for both or neither; count never exceeds DEPTH and never goes below 0.
REQ-026 SHALL, in LIFO mode with push_acc and pop_acc together, return the old top element and replace the top slot with data_in.
REQ-027 SHALL, in FIFO mode, wrap the read and write pointers from DEPTH-1 to 0; with push_acc and pop_acc together, both pointers advance.
REQ-028 SHALL load mode_o from mode_i only at an edge where count is 0 and no push_acc occurs; otherwise a change on mode_i is ignored until that condition holds.
REQ-029 SHALL, on flush, set count to 0 and clear both pointers at the next edge, taking priority over push and pop. A flush SHALL NOT write memory, SHALL NOT assert data_valid, and SHALL NOT set the error flags.
REQ-030 SHALL drive full, empty and almost_full combinationally from count.
REQ-031 SHALL NOT require entry contents to be reset; an element is observable only after it has been written.

Reset
REQ-032 SHALL, when syn_n_rst is 0 at a rising clk edge, set count to 0, clear the pointers, and set data_out to 0, data_valid to 0, overflow to 0 and underflow to 0.
REQ-033 SHALL, on the same reset, load mode_o from mode_i.
REQ-034 SHALL give reset priority over flush, push, pop and err_clr; a reset mid-stream discards all stored entries.

Configuration
REQ-035 SHALL, with STACK_QUEUE_ERR_EN defined, set overflow when push is 1 and push_acc is 0, and set underflow when pop is 1 and empty is 1.
REQ-036 SHALL keep both flags set until err_clr or reset; when err_clr and a new error occur in the same cycle, the flag SHALL remain set.
REQ-037 SHALL, with STACK_QUEUE_ERR_EN undefined, tie overflow and underflow to 0 and ignore err_clr; all other behaviour is identical.

Verification
REQ-038 SHALL cover LIFO fill-and-drain: DEPTH=8, push 0x01..0x08 -> full=1, almost_full=1 from count 7; then 8 pops -> data_out 0x08..0x01 each with data_valid, empty=1.
REQ-039 SHALL cover FIFO wrap-around: mode_i=1 while empty; push 0x10..0x15, pop 4, push 0x16..0x1B -> pops return 0x14..0x1B in order, count reaches 0.
REQ-040 SHALL cover simultaneous push and pop when full: LIFO full with top 0x08; push 0xAA with pop -> data_out=0x08, count stays 8, next pop returns 0xAA. FIFO full -> oldest element returned, 0xAA enqueued at tail.
REQ-041 SHALL cover error flags with STACK_QUEUE_ERR_EN defined: push when full without pop -> overflow=1 and data dropped; pop when empty -> underflow=1; err_clr -> both 0. With the macro undefined, both flags stay 0.
REQ-042 SHALL cover a gated mode switch: count=3 in LIFO, mode_i=1 -> mode_o stays 0; drain to empty -> mode_o=1 at the next edge.
REQ-043 SHALL cover flush and reset: count=5, flush -> count=0, data_valid=0. Reset asserted during a push -> count=0, data_out=0, push discarded.

Source files
------------

// File: rtl/stack_queue.sv
// stack_queue: single-port-clock storage block that behaves as a LIFO stack
// (mode 0) or a circular FIFO (mode 1), with registered read data, occupancy
// flags and optional sticky error flags.
// Optional feature macro: STACK_QUEUE_ERR_EN enables the overflow/underflow
// sticky flags; when undefined both flags are tied low and err_clr is ignored.
module stack_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          syn_n_rst,
    input  logic                          mode_i,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic                          err_clr,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          mode_o,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic MODE_LIFO = 1'b0;

    // Storage is never reset; an entry is only read after it was written.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  mode_q, mode_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  pop_acc, push_acc;
    logic                  mem_we;
    logic [PW-1:0]         mem_waddr;
    logic [PW-1:0]         top_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_THRESH));

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign mode_o     = mode_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    // Flush overrides any request in the same cycle, so it also masks acceptance.
    assign pop_acc  = pop && !empty && !flush;
    assign push_acc = push && (!full || pop_acc) && !flush;

    // Top-of-stack slot; only meaningful when the stack is non-empty.
    assign top_idx = PW'(count_q - CW'(1));

    // Next-state for occupancy, pointers, read data, mode and memory write port.
    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        mode_d       = mode_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;

        // Mode may only change while nothing is stored and nothing is arriving.
        if ((count_q == '0) && !push_acc) begin
            mode_d = mode_i;
        end

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_acc && !pop_acc) begin
                count_d = count_q + CW'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CW'(1);
            end

            if (mode_q == MODE_LIFO) begin
                if (pop_acc) begin
                    data_out_d   = mem_q[top_idx];
                    data_valid_d = 1'b1;
                    // Simultaneous push replaces the slot just read.
                    if (push_acc) begin
                        mem_we    = 1'b1;
                        mem_waddr = top_idx;
                    end
                end else if (push_acc) begin
                    mem_we    = 1'b1;
                    mem_waddr = PW'(count_q);
                end
            end else begin
                if (pop_acc) begin
                    data_out_d   = mem_q[rd_ptr_q];
                    data_valid_d = 1'b1;
                    rd_ptr_d     = ptr_inc(rd_ptr_q);
                end
                if (push_acc) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q;
                    wr_ptr_d  = ptr_inc(wr_ptr_q);
                end
            end
        end
    end

`ifdef STACK_QUEUE_ERR_EN
    // Sticky error flags: a new error in the same cycle as err_clr wins.
    always_comb begin
        overflow_d  = overflow_q && !err_clr;
        underflow_d = underflow_q && !err_clr;
        if (push && !push_acc && !flush) begin
            overflow_d = 1'b1;
        end
        if (pop && empty && !flush) begin
            underflow_d = 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    // Error reporting disabled: flags held low.
    always_comb begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
    end
`endif

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!syn_n_rst) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            mode_q       <= mode_i;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            mode_q       <= mode_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage write port; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (syn_n_rst && mem_we) begin
            mem_q[mem_waddr] <= data_in;
        end
    end

endmodule

// File: tb/tb_stack_queue.sv
// tb_stack_queue: directed scenarios plus randomized traffic for stack_queue,
// checked cycle by cycle against a queue-based reference model.
module tb_stack_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode_i = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, mode_o, overflow, underflow;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_dv, m_mode, m_ovf, m_unf;

    stack_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF)) dut (
        .clk(clk), .syn_n_rst(rst_n), .mode_i(mode_i), .push(push), .pop(pop),
        .flush(flush), .err_clr(err_clr), .data_in(data_in), .data_out(data_out),
        .data_valid(data_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .mode_o(mode_o), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Advance one clock, update the model from the sampled inputs, compare outputs.
    task automatic tick();
        bit e, f, pa, wa, mchg;
        e    = (mq.size() == 0);
        f    = (mq.size() == DEPTH);
        pa   = pop && !e && !flush;
        wa   = push && (!f || pa) && !flush;
        mchg = e && !wa;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_mode = mode_i;
        end else begin
            m_dv = 1'b0;
`ifdef STACK_QUEUE_ERR_EN
            if (err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (push && !wa && !flush) m_ovf = 1'b1;
            if (pop && e && !flush)    m_unf = 1'b1;
`endif
            if (flush) begin
                mq.delete();
            end else if (!m_mode) begin
                if (pa) begin
                    m_dout = mq[mq.size()-1];
                    m_dv   = 1'b1;
                    if (wa) mq[mq.size()-1] = data_in;
                    else    void'(mq.pop_back());
                end else if (wa) begin
                    mq.push_back(data_in);
                end
            end else begin
                if (pa) begin
                    m_dout = mq.pop_front();
                    m_dv   = 1'b1;
                end
                if (wa) mq.push_back(data_in);
            end
            if (mchg) m_mode = mode_i;
        end
        #1;
        chk("dout",  32'(data_out),    32'(m_dout));
        chk("dvld",  32'(data_valid),  32'(m_dv));
        chk("count", 32'(count),       32'(mq.size()));
        chk("full",  32'(full),        32'(mq.size() == DEPTH));
        chk("empty", 32'(empty),       32'(mq.size() == 0));
        chk("afull", 32'(almost_full), 32'(mq.size() >= AF));
        chk("mode",  32'(mode_o),      32'(m_mode));
        chk("ovf",   32'(overflow),    32'(m_ovf));
        chk("unf",   32'(underflow),   32'(m_unf));
    endtask

    task automatic cyc(input bit p, input bit r, input logic [DW-1:0] d);
        push    = p;
        pop     = r;
        data_in = d;
        tick();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset(input bit m);
        mode_i = m;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset(1'b0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout",  32'(data_out), 0);
        chk("rst_empty", 32'(empty), 1);

        // LIFO fill and drain
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1, 0, DW'(i));
            if (i == 6) chk("af_at6", 32'(almost_full), 0);
            if (i == 7) chk("af_at7", 32'(almost_full), 1);
        end
        chk("lifo_full", 32'(full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, '0);
            chk("lifo_pop", 32'(data_out), 32'(DEPTH - i));
            chk("lifo_vld", 32'(data_valid), 1);
        end
        chk("lifo_empty", 32'(empty), 1);

        // FIFO wrap-around
        mode_i = 1'b1;
        cyc(0, 0, '0);
        chk("fifo_mode", 32'(mode_o), 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, DW'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, '0);
            chk("fifo_pop1", 32'(data_out), 32'(8'h10 + i));
        end
        for (int i = 0; i < 6; i++) cyc(1, 0, DW'(8'h16 + i));
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, '0);
            chk("fifo_pop2", 32'(data_out), 32'(8'h14 + i));
        end
        chk("fifo_cnt0", 32'(count), 0);

        // Simultaneous push/pop when full, LIFO then FIFO
        mode_i = 1'b0;
        cyc(0, 0, '0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, DW'(i));
        cyc(1, 1, 8'hAA);
        chk("lifo_pp_dout", 32'(data_out), 8'h08);
        chk("lifo_pp_cnt",  32'(count), DEPTH);
        cyc(0, 1, '0);
        chk("lifo_pp_next", 32'(data_out), 8'hAA);
        // overflow: push into full without pop
        cyc(1, 0, '0);
        cyc(1, 0, 8'h55);
`ifdef STACK_QUEUE_ERR_EN
        chk("ovf_set", 32'(overflow), 1);
`else
        chk("ovf_off", 32'(overflow), 0);
`endif
        cyc(0, 1, '0);
        chk("ovf_drop", 32'(data_out), 8'h00);
        while (!empty) cyc(0, 1, '0);
        cyc(0, 1, '0);
`ifdef STACK_QUEUE_ERR_EN
        chk("unf_set", 32'(underflow), 1);
`else
        chk("unf_off", 32'(underflow), 0);
`endif
        err_clr = 1'b1;
        cyc(0, 0, '0);
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        chk("unf_clr", 32'(underflow), 0);

        mode_i = 1'b1;
        cyc(0, 0, '0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, DW'(i));
        cyc(1, 1, 8'hAA);
        chk("fifo_pp_dout", 32'(data_out), 8'h01);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0);
        chk("fifo_pp_tail", 32'(data_out), 8'hAA);

        // Gated mode switch
        mode_i = 1'b0;
        cyc(0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(1, 0, DW'(i + 1));
        mode_i = 1'b1;
        cyc(0, 0, '0);
        chk("mode_hold", 32'(mode_o), 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, '0);
        chk("mode_still", 32'(mode_o), 0);
        cyc(0, 0, '0);
        chk("mode_switch", 32'(mode_o), 1);

        // Flush, then reset during push
        for (int i = 0; i < 5; i++) cyc(1, 0, DW'(8'h30 + i));
        flush = 1'b1;
        cyc(1, 1, 8'hEE);
        flush = 1'b0;
        chk("flush_cnt", 32'(count), 0);
        chk("flush_vld", 32'(data_valid), 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'h40 + i));
        cyc(0, 1, '0);
        push    = 1'b1;
        data_in = 8'h77;
        do_reset(1'b0);
        push = 1'b0;
        chk("rst_push_cnt",  32'(count), 0);
        chk("rst_push_dout", 32'(data_out), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph      = (i / 150) % 3;
            rst_n   = ($urandom_range(0, 299) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) mode_i = ~mode_i;
            push    = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                      (ph == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            pop     = (ph == 1) ? ($urandom_range(0, 3) != 0) :
                      (ph == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            data_in = DW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
